// File: rtl/hs_req_sender.sv
// hs_req_sender: transmitting end of a four-phase req/ack handshake.
// A local word is captured on acceptance and held on req_data. req is raised,
// the remote ack is synchronised into clk, and the return-to-zero phase is
// completed before done pulses. If ack never rises, err pulses and the sender
// waits in RECOVER for any late ack to fall.
module hs_req_sender #(
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_STAGES    = 2,   // legal range 2..4
  parameter int TIMEOUT_CYCLES = 255  // 0 disables the ack-rise timeout
) (
  input  logic                  clk,
  input  logic                  n_rst,      // synchronous, active-high
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  input  logic                  async_ack,
  output logic                  req,
  output logic [DATA_WIDTH-1:0] req_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // Counter is cleared on entry to REQ_HI and stops at TIMEOUT_CYCLES-1,
  // so it never needs more than clog2(TIMEOUT_CYCLES+1) bits.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ_HI  = 2'd1,
    ST_ACK_LO  = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    req_q, req_d;
  logic [DATA_WIDTH-1:0]   req_data_q, req_data_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic ack_s;
  logic accept;
  logic timeout_hit;

  // Only the last synchroniser stage is ever looked at by the FSM.
  assign ack_s       = sync_q[SYNC_STAGES-1];
  assign accept      = tx_valid & tx_ready;
  assign timeout_hit = TIMEOUT_EN & (cnt_q == CNT_LAST);

  // Ack synchroniser: async_ack shifts in at stage 0 and reaches ack_s after SYNC_STAGES edges.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_ack};
    end
  end

  // State and datapath registers; reset drops req on the very next edge.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      req_data_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      req_data_q <= req_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: an ack seen on the final count wins over the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_REQ_HI;
      end
      ST_REQ_HI: begin
        if (ack_s)            state_d = ST_ACK_LO;
        else if (timeout_hit) state_d = ST_RECOVER;
      end
      ST_ACK_LO: begin
        if (!ack_s) state_d = ST_IDLE;
      end
      ST_RECOVER: begin
        if (!ack_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: capture word on acceptance, count while waiting, one-cycle pulses.
  always_comb begin
    cnt_d      = cnt_q;
    req_data_d = req_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    req_d      = (state_d == ST_REQ_HI);
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_data_d = tx_data;
          cnt_d      = '0;
        end
      end
      ST_REQ_HI: begin
        if (!ack_s) begin
          if (timeout_hit)     err_d = 1'b1;
          else if (TIMEOUT_EN) cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ACK_LO: begin
        if (!ack_s) done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Outputs: tx_ready blocked during reset and while a stale ack is still high.
  always_comb begin
    tx_ready = (state_q == ST_IDLE) & ~ack_s & ~n_rst;
    busy     = (state_q != ST_IDLE);
    req      = req_q;
    req_data = req_data_q;
    done     = done_q;
    err      = err_q;
  end

endmodule

// File: tb/tb_hs_req_sender.sv
// Bench for hs_req_sender: directed handshake scenarios followed by random
// traffic, all compared every cycle against a cycle-level behavioural model.
module tb_hs_req_sender;

  localparam int DW = 8;
  localparam int SS = 2;
  localparam int TO = 4;

  localparam int P_IDLE      = 0;
  localparam int P_WAIT_RISE = 1;
  localparam int P_WAIT_FALL = 2;
  localparam int P_RECOVER   = 3;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_ready;
  logic          async_ack;
  logic          req;
  logic [DW-1:0] req_data;
  logic          busy;
  logic          done;
  logic          err;

  hs_req_sender #(
    .DATA_WIDTH(DW), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .n_rst(n_rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .async_ack(async_ack), .req(req), .req_data(req_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int            m_phase = P_IDLE;
  int            m_wait  = 0;
  logic [DW-1:0] m_data  = '0;
  bit            m_done  = 0;
  bit            m_err   = 0;
  bit            m_hist[$];        // ack samples, newest first
  bit            exp_ready = 0;
  bit            accepted  = 0;
  logic [DW-1:0] sb[$];            // accepted words awaiting completion

  // Ack responder
  int ack_mode = 0;                // 0: driven directly, 1: echo of req
  int echo_d   = 0;                // echo delay in cycles
  bit req_seen[$];                 // observed req, newest first

  int n_done = 0;
  int n_err  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model on the edge, compare outputs 1ns later, drive the echo.
  task automatic step();
    bit            acks;
    logic [DW-1:0] w;
    acks     = m_hist[SS-1];
    accepted = 0;
    @(posedge clk);
    if (n_rst) begin
      m_phase = P_IDLE; m_wait = 0; m_data = '0; m_done = 0; m_err = 0;
      foreach (m_hist[k]) m_hist[k] = 0;
      sb.delete();
    end else begin
      m_done = 0; m_err = 0;
      case (m_phase)
        P_IDLE: if (tx_valid && !acks) begin
          m_data = tx_data; sb.push_back(tx_data);
          m_phase = P_WAIT_RISE; m_wait = 0; accepted = 1;
        end
        P_WAIT_RISE: begin
          if (acks) m_phase = P_WAIT_FALL;
          else if (m_wait == TO - 1) begin m_err = 1; m_phase = P_RECOVER; end
          else m_wait++;
        end
        P_WAIT_FALL: if (!acks) begin m_done = 1; m_phase = P_IDLE; end
        default: if (!acks) m_phase = P_IDLE;
      endcase
      m_hist.push_front(async_ack);
      void'(m_hist.pop_back());
    end
    #1;
    exp_ready = !n_rst && (m_phase == P_IDLE) && !m_hist[SS-1];
    chk("tx_ready", tx_ready, exp_ready);
    chk("req", req, m_phase == P_WAIT_RISE);
    chk("req_data", req_data, m_data);
    chk("busy", busy, m_phase != P_IDLE);
    chk("done", done, m_done);
    chk("err", err, m_err);
    chk("done_err_excl", done & err, 0);
    chk("ready_while_busy", tx_ready & busy, 0);
    if (done || err) begin
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL sb_underflow observed=%0d expected=%0d", sb.size(), 1);
      end
      if (sb.size() > 0) begin
        w = sb.pop_front();
        if (done) chk("sb_word", req_data, w);
      end
    end
    if (done) begin n_done++; $display("txn done word=%02h", req_data); end
    if (err)  begin n_err++;  $display("txn timeout word=%02h", req_data); end
    req_seen.push_front(req);
    if (req_seen.size() > 8) void'(req_seen.pop_back());
    if (ack_mode == 1) async_ack = (req_seen.size() > echo_d) ? req_seen[echo_d] : 1'b0;
  endtask

  task automatic clear_echo();
    req_seen.delete();
  endtask

  initial begin : main
    logic [9:0]  r_pat, d_pat;
    logic [11:0] rdy_pat;
    int          cnt_req, nd0, ne0, n, got_dones;
    for (int i = 0; i < SS; i++) m_hist.push_back(0);

    // 1. Reset with tx_valid held high
    n_rst = 1; tx_valid = 1; tx_data = 8'h3C; async_ack = 0; ack_mode = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_rst_ready", tx_ready, 0);
      chk("t1_rst_req", req, 0);
    end
    n_rst = 0; tx_valid = 0;
    step();
    chk("t1_ready_after_release", tx_ready, 1);

    // 2. Single transfer, zero-delay echo
    tx_valid = 1; tx_data = 8'hA5; ack_mode = 1; echo_d = 0; clear_echo();
    ne0 = n_err; r_pat = '0; d_pat = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) tx_valid = 0;
      r_pat[i] = req; d_pat[i] = done;
      chk("t2_hold", req_data, 8'hA5);
    end
    chk("t2_req_pattern", r_pat, 10'b0000000111);
    chk("t2_done_pattern", d_pat, 10'b0001000000);
    chk("t2_no_err", n_err - ne0, 0);

    // 3. Back-to-back transfers
    tx_valid = 1; tx_data = 8'h01; nd0 = n_done; n = 0; got_dones = 0;
    for (int i = 0; i < 60 && got_dones < 2; i++) begin
      step();
      if (done) begin
        chk("t3_order", req_data, (got_dones == 0) ? 8'h01 : 8'h02);
        got_dones++;
      end
      if (accepted) begin
        n++;
        if (n == 1) tx_data = 8'h02; else tx_valid = 0;
      end
    end
    tx_valid = 0;
    chk("t3_done_count", n_done - nd0, 2);
    chk("t3_accept_count", n, 2);

    // 4a. Timeout, ack never rises
    ack_mode = 0; async_ack = 0; tx_valid = 1; tx_data = 8'h77;
    nd0 = n_done; ne0 = n_err; cnt_req = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 0) tx_valid = 0;
      cnt_req += int'(req);
    end
    chk("t4_req_cycles", cnt_req, TO);
    chk("t4_err_count", n_err - ne0, 1);
    chk("t4_no_done", n_done - nd0, 0);
    chk("t4_idle", busy, 0);

    // 4b. Timeout with late ack absorbed in RECOVER
    ack_mode = 1; echo_d = 2; clear_echo(); tx_valid = 1; tx_data = 8'h9E;
    nd0 = n_done; ne0 = n_err; rdy_pat = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 0) tx_valid = 0;
      rdy_pat[i] = tx_ready;
    end
    chk("t4b_ready_pattern", rdy_pat, 12'hE00);
    chk("t4b_err_count", n_err - ne0, 1);
    chk("t4b_no_done", n_done - nd0, 0);

    // 5. Ack seen on the final count: ack wins
    echo_d = 1; clear_echo(); tx_valid = 1; tx_data = 8'h5C;
    nd0 = n_done; ne0 = n_err; cnt_req = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (i == 0) tx_valid = 0;
      cnt_req += int'(req);
    end
    chk("t5_req_cycles", cnt_req, TO);
    chk("t5_no_err", n_err - ne0, 0);
    chk("t5_done_count", n_done - nd0, 1);

    // 6. Reset mid-handshake with ack high
    ack_mode = 0; async_ack = 0; tx_valid = 1; tx_data = 8'h5A;
    step();
    tx_valid = 0; async_ack = 1;
    step();
    chk("t6_in_req_hi", req, 1);
    nd0 = n_done; ne0 = n_err;
    n_rst = 1;
    step();
    chk("t6_req_dropped", req, 0);
    step();
    n_rst = 0;
    for (int i = 0; i < 4; i++) step();
    chk("t6_ready_blocked", tx_ready, 0);
    chk("t6_no_done_err", (n_done - nd0) + (n_err - ne0), 0);
    async_ack = 0; n = 0;
    for (int i = 0; i < 10 && !tx_ready; i++) begin
      step();
      n++;
    end
    chk("t6_ready_latency", n, SS);

    // Random traffic
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 299) == 0) n_rst = 1; else n_rst = 0;
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = DW'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        ack_mode = ($urandom_range(0, 3) == 0) ? 0 : 1;
        echo_d   = $urandom_range(0, 4);
      end
      if (ack_mode == 0 && $urandom_range(0, 7) == 0) async_ack = 1'($urandom_range(0, 1));
      step();
    end
    n_rst = 0; tx_valid = 0; ack_mode = 0; async_ack = 0;
    for (int i = 0; i < 20; i++) step();
    chk("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hs_req_sender.md
Name: hs_req_sender

Overview:
Transmitting end of the four-phase request/acknowledge crossing into an asynchronous neighbour.
- Accepts a word from the local clock domain and holds it stable on req_data.
- Raises req and waits for the remote ack, brought in through an internal SYNC_STAGES-deep synchronizer.
- Completes the return-to-zero handshake, then signals done.
- Sits between local logic (e.g. bus-slave register writes) and any async consumer.

Parameters:
DATA_WIDTH, 8, width of transferred word
SYNC_STAGES, 2, flops in ack synchronizer chain (legal range 2..4)
TIMEOUT_CYCLES, 255, max cycles to wait for ack rise; 0 disables timeout

Ports:
clk  in  1  system clock, all logic on rising edge
n_rst  in  1  reset, synchronous, active-high (1 = reset)
tx_valid  in  1  local word available
tx_data  in  DATA_WIDTH  local word
tx_ready  out  1  sender can accept; transfer occurs on edge where tx_valid & tx_ready
async_ack  in  1  remote acknowledge, asynchronous to clk
req  out  1  request to remote, registered
req_data  out  DATA_WIDTH  held word, registered
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse: handshake completed normally
err  out  1  one-cycle pulse: ack-rise timeout

Behaviour:
- Reset (n_rst=1 at an edge, any state):
  - state=IDLE; sync chain all 0; timeout counter 0.
  - Outputs after that edge: req=0, req_data=0, done=0, err=0, busy=0.
  - tx_ready=0 during reset, then follows the IDLE rule.
  - Reset mid-handshake drops req immediately.
- ack_s = last stage of the sync chain. async_ack reaches ack_s after SYNC_STAGES edges. FSM uses only ack_s.
- tx_ready = (state==IDLE) & ~ack_s. This is combinational from registered signals.
- IDLE: on tx_valid & tx_ready:
  - req_data <= tx_data; req <= 1; counter <= 0; -> REQ_HI.
  - tx_valid while tx_ready=0 is ignored (not queued).
- REQ_HI (req=1):
  - ack_s=1: req <= 0; -> ACK_LO.
  - Otherwise, if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: err pulses next cycle; req <= 0; -> RECOVER.
  - Otherwise counter <= counter+1.
  - If ack_s=1 and the timeout fire on the same edge, ack wins: no err.
- ACK_LO (req=0, waiting ack fall):
  - ack_s=0: done pulses next cycle; -> IDLE.
  - No timeout in this state.
- RECOVER (req=0):
  - ack_s=0: -> IDLE. No done. A late ack is absorbed here.
- Data stability: req_data changes only on the IDLE acceptance edge. It is held through REQ_HI, ACK_LO and RECOVER, and stays valid after done.
- Counter width: clog2(TIMEOUT_CYCLES+1), minimum 1 bit. No wrap, because it is cleared on entry to REQ_HI.
- Best-case latency, with ack following req instantly:
  - Acceptance edge E: req=1 after E.
  - ack_s=1 after E+SYNC_STAGES; req falls at E+SYNC_STAGES+1.
  - done is high during the cycle following edge E+2*SYNC_STAGES+2.
  - Next acceptance is possible on the following edge.
- ack_s high while in IDLE (stray or stale ack): tx_ready held 0 until ack_s falls. No spurious req.
- done and err are never high together. busy=1 in REQ_HI, ACK_LO and RECOVER.

Test Plan:
1. Reset: assert n_rst 3 cycles with tx_valid=1, async_ack=0 -> req=0, req_data=0, tx_ready=0 during reset; tx_ready=1 the cycle after release.
2. Single transfer, SYNC_STAGES=2: tx_data=8'hA5 accepted at edge E; bench echoes ack=req with 0 delay -> req high for edges E+1..E+3; req_data=A5 throughout; done is one pulse, high during the cycle following edge E+6; no err.
3. Back-to-back transfers: tx_valid held with data 8'h01 then 8'h02 -> two complete handshakes in order; tx_ready low while busy; req_data 01 then 02; exactly two done pulses; no words lost or duplicated.
4. Timeout, TIMEOUT_CYCLES=4: ack never rises -> req high exactly 4 cycles; err 1-cycle pulse; state IDLE; no done. Repeat with ack rising late, during RECOVER -> tx_ready stays 0 until ack falls; no done.
5. Ack and timeout on the same edge: ack timed so ack_s=1 on the final count -> req drops; done later; err never asserted.
6. Reset mid-handshake: n_rst=1 in REQ_HI with ack high -> req=0 next edge; no done or err. After release, tx_ready stays 0 until async_ack low for SYNC_STAGES cycles.
